// File: rtl/uart_tx_top.sv
// ---------------------------------------------------------------------------
// uart_tx_top
//
// Board-level UART transmitter. The centre push-button is synchronised and
// debounced. Each debounced press sends the 8-bit switch value as one serial
// frame: start bit, 8 data bits LSB first, parity bit, stop bit(s).
//
// Ports
//   CLK100MHZ     in   1  system clock, all flops on the rising edge
//   CPU_RESET     in   1  asynchronous, active-high reset
//   SW            in   8  character to send
//   BTNC          in   1  raw, bouncy, asynchronous push-button
//   LED           out  8  combinational mirror of SW
//   UART_RXD_OUT  out  1  serial TX line, idles high, driven from a flop
//   LED16_B       out  1  transmitter busy, driven from a flop
//
// Parameters
//   CLK_FREQUENCY     input clock in Hz
//   BAUD_RATE         bit rate; BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE
//   PARITY            1 = odd parity, 0 = even parity
//   DEBOUNCE_TIME_US  button stable time in microseconds
//
// Build option
//   TX_TWO_STOP_EN    when defined, the frame ends with two stop bits
//                     (12 bit times). Busy stays high through both.
//                     When undefined, a single stop bit (11 bit times).
// ---------------------------------------------------------------------------
module uart_tx_top #(
  parameter int unsigned CLK_FREQUENCY    = 100_000_000,
  parameter int unsigned BAUD_RATE        = 19_200,
  parameter logic        PARITY           = 1'b1,
  parameter int unsigned DEBOUNCE_TIME_US = 10_000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESET,
  input  logic [7:0] SW,
  input  logic       BTNC,
  output logic [7:0] LED,
  output logic       UART_RXD_OUT,
  output logic       LED16_B
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int unsigned BAUD_CLOCKS     = CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned BAUD_W          = (BAUD_CLOCKS > 1) ? $clog2(BAUD_CLOCKS) : 1;
  localparam int unsigned DEBOUNCE_CLOCKS = (CLK_FREQUENCY / 1_000_000) * DEBOUNCE_TIME_US;
  localparam int unsigned DB_W            = $clog2(DEBOUNCE_CLOCKS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CLOCKS - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CLOCKS - 1);
  localparam logic [DB_W-1:0]   DB_ZERO   = {DB_W{1'b0}};
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);

  // Index of the last stop bit; the bit counter is reused to count stop bits.
`ifdef TX_TWO_STOP_EN
  localparam logic [2:0] STOP_LAST = 3'd1;
`else
  localparam logic [2:0] STOP_LAST = 3'd0;
`endif

  // Transmitter states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity bit for a data byte: with PARITY=1 the ones in data+parity are odd.
  function automatic logic tx_parity(input logic [7:0] d);
    return (^d) ^ PARITY;
  endfunction

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic            sync1_r;
  logic            sync2_r;
  logic            db_r;
  logic            db_prev_r;
  logic [DB_W-1:0] db_cnt_r;
  logic            send_s;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [BAUD_W-1:0] baud_cnt_r;
  logic [BAUD_W-1:0] baud_cnt_nxt_s;
  logic [2:0]        bit_cnt_r;
  logic [2:0]        bit_cnt_nxt_s;
  logic [7:0]        data_r;
  logic [7:0]        data_nxt_s;
  logic              baud_tick_s;
  logic              line_r;
  logic              line_nxt_s;
  logic              busy_r;

  // -------------------------------------------------------------------------
  // Switch mirror
  // -------------------------------------------------------------------------
  assign LED = SW;

  // -------------------------------------------------------------------------
  // Button path
  // -------------------------------------------------------------------------

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= BTNC;
      sync2_r <= sync1_r;
    end
  end

  // Debouncer: the output follows the input only after the input has disagreed
  // with it for DEBOUNCE_CLOCKS consecutive cycles; any agreement restarts the count.
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      db_r     <= 1'b0;
      db_cnt_r <= DB_ZERO;
    end else if (sync2_r != db_r) begin
      if (db_cnt_r == DB_LAST) begin
        db_r     <= sync2_r;
        db_cnt_r <= DB_ZERO;
      end else begin
        db_cnt_r <= db_cnt_r + DB_ONE;
      end
    end else begin
      db_cnt_r <= DB_ZERO;
    end
  end

  // Previous debounced level, for rising-edge detection.
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      db_prev_r <= 1'b0;
    end else begin
      db_prev_r <= db_r;
    end
  end

  // One-cycle send request on each debounced press; holding does not repeat it.
  assign send_s = db_r & ~db_prev_r;

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  assign baud_tick_s = (baud_cnt_r == BAUD_LAST);

  // Next-state, baud counter, bit counter and data latch.
  always_comb begin
    state_nxt_s    = state_r;
    baud_cnt_nxt_s = baud_cnt_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    data_nxt_s     = data_r;

    // The baud counter runs in every active state and wraps at BAUD_CLOCKS-1.
    if (state_r == S_IDLE) begin
      baud_cnt_nxt_s = BAUD_ZERO;
    end else if (baud_tick_s) begin
      baud_cnt_nxt_s = BAUD_ZERO;
    end else begin
      baud_cnt_nxt_s = baud_cnt_r + BAUD_ONE;
    end

    case (state_r)
      S_IDLE: begin
        // A send request while busy never reaches here, so it is dropped.
        if (send_s) begin
          data_nxt_s    = SW;
          bit_cnt_nxt_s = 3'd0;
          state_nxt_s   = S_START;
        end else begin
          bit_cnt_nxt_s = 3'd0;
        end
      end
      S_START: begin
        if (baud_tick_s) begin
          state_nxt_s = S_DATA;
        end else begin
          state_nxt_s = S_START;
        end
      end
      S_DATA: begin
        if (baud_tick_s) begin
          // After bit 7 the counter wraps to 0, ready for counting stop bits.
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_nxt_s = S_PARITY;
          end else begin
            state_nxt_s = S_DATA;
          end
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (baud_tick_s) begin
          bit_cnt_nxt_s = 3'd0;
          state_nxt_s   = S_STOP;
        end else begin
          state_nxt_s = S_PARITY;
        end
      end
      S_STOP: begin
        if (baud_tick_s) begin
          if (bit_cnt_r == STOP_LAST) begin
            bit_cnt_nxt_s = 3'd0;
            state_nxt_s   = S_IDLE;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            state_nxt_s   = S_STOP;
          end
        end else begin
          state_nxt_s = S_STOP;
        end
      end
      default: begin
        // Unreachable encodings recover to IDLE.
        state_nxt_s    = S_IDLE;
        baud_cnt_nxt_s = BAUD_ZERO;
        bit_cnt_nxt_s  = 3'd0;
      end
    endcase
  end

  // Line level for the current state; registered below so the pin is glitch-free.
  always_comb begin
    line_nxt_s = 1'b1;
    case (state_r)
      S_IDLE:   line_nxt_s = 1'b1;
      S_START:  line_nxt_s = 1'b0;
      S_DATA:   line_nxt_s = data_r[bit_cnt_r];
      S_PARITY: line_nxt_s = tx_parity(data_r);
      S_STOP:   line_nxt_s = 1'b1;
      default:  line_nxt_s = 1'b1;
    endcase
  end

  // Transmitter state registers.
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      state_r    <= S_IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 3'd0;
      data_r     <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      baud_cnt_r <= baud_cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      data_r     <= data_nxt_s;
    end
  end

  // Output flops: line and busy follow the state one cycle later; reset
  // forces the line high and busy low immediately, aborting any frame.
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      line_r <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      line_r <= line_nxt_s;
      busy_r <= (state_r != S_IDLE);
    end
  end

  assign UART_RXD_OUT = line_r;
  assign LED16_B      = busy_r;

endmodule

// File: tb/tb_uart_tx_top.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_top
//
// Drives two instances of uart_tx_top from the same inputs: one with odd
// parity and one with even parity. The clock is scaled down so that a bit is
// 16 cycles and the debounce time is 40 cycles. Expected characters are queued
// when a press is driven. A receiver model decodes each frame at mid-bit and
// compares it against the head of the queue.
// ---------------------------------------------------------------------------
module tb_uart_tx_top;

  localparam int unsigned CLK_HZ   = 1_000_000;
  localparam int unsigned BAUD     = 62_500;
  localparam int unsigned DB_US    = 40;
  localparam int          B        = CLK_HZ / BAUD;             // 16
  localparam int          DB       = (CLK_HZ / 1_000_000) * DB_US; // 40
  localparam int          FRAME    = 11 * B;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       btnc;
  logic [7:0] led,  led_e;
  logic       line, line_e;
  logic       busy, busy_e;

  uart_tx_top #(
    .CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(1'b1), .DEBOUNCE_TIME_US(DB_US)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESET(rst), .SW(sw), .BTNC(btnc),
    .LED(led), .UART_RXD_OUT(line), .LED16_B(busy)
  );

  uart_tx_top #(
    .CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(1'b0), .DEBOUNCE_TIME_US(DB_US)
  ) dut_even (
    .CLK100MHZ(clk), .CPU_RESET(rst), .SW(sw), .BTNC(btnc),
    .LED(led_e), .UART_RXD_OUT(line_e), .LED16_B(busy_e)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         frames_rx = 0;
  int         last_busy_len = 0;
  logic       last_par_even = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Receiver model: detects the start bit, samples every bit at mid-bit and
  // checks the frame against the scoreboard. Reset aborts the frame in flight.
  initial begin : rx_model
    logic [7:0] d;
    logic       st, par, par_e, stp;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && line == 1'b0) begin
        aborted = 1'b0;
        d = 8'h00;
        for (int s = 0; s < 11 && !aborted; s++) begin
          for (int k = 0; k < ((s == 0) ? B / 2 : B); k++) begin
            if (k > 0 || s > 0) @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          if (!aborted) begin
            if (s == 0) st = line;
            else if (s <= 8) d[s-1] = line;
            else if (s == 9) begin par = line; par_e = line_e; end
            else stp = line;
          end
        end
        if (aborted) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          wait (!rst);
        end else begin
          check("rx_start", {31'd0, st}, 32'd0);
          check("rx_stop", {31'd0, stp}, 32'd1);
          check("rx_parity_odd", {31'd0, par}, {31'd0, ~(^d)});
          check("rx_parity_even", {31'd0, par_e}, {31'd0, ^d});
          last_par_even = par_e;
          if (exp_q.size() == 0) begin
            check("rx_unexpected_frame", {24'd0, d}, 32'hFFFF_FFFF);
          end else begin
            check("rx_data", {24'd0, d}, {24'd0, exp_q.pop_front()});
          end
          frames_rx++;
        end
      end
    end
  end

  // Measures how many cycles each busy interval lasts.
  initial begin : busy_meter
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        n++;
      end else begin
        if (n != 0) last_busy_len = n;
        n = 0;
      end
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frames_rx < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_timeout", {31'd0, frames_rx >= target}, 32'd1);
  endtask

  // Counts cycles in which the line or busy is not idle.
  task automatic quiet(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (line !== 1'b1 || busy !== 1'b0) bad++;
    end
  endtask

  task automatic press_bouncy(input int hold);
    for (int i = 0; i < 4; i++) begin
      btnc = 1'b1; repeat ($urandom_range(2, 10)) @(negedge clk);
      btnc = 1'b0; repeat ($urandom_range(2, 10)) @(negedge clk);
    end
    btnc = 1'b1;
    repeat (hold) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      btnc = 1'b0; repeat ($urandom_range(2, 10)) @(negedge clk);
      btnc = 1'b1; repeat ($urandom_range(2, 10)) @(negedge clk);
    end
    btnc = 1'b0;
  endtask

  initial begin : main
    int bad;
    int k;
    logic [7:0] c;

    rst  = 1'b1;
    sw   = 8'h00;
    btnc = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_line", {31'd0, line}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Idle after reset: LED mirrors switches, line stays idle.
    sw = 8'hA5;
    @(negedge clk);
    check("led_a5", {24'd0, led}, 32'h0000_00A5);
    quiet(20, bad);
    sw = 8'h5A;
    @(negedge clk);
    check("led_5a", {24'd0, led}, 32'h0000_005A);
    quiet(20, k);
    check("idle_quiet", bad + k, 32'd0);

    // Short pulse followed by bounces: never a start bit.
    btnc = 1'b1; repeat (DB / 2) @(negedge clk);
    btnc = 1'b0;
    bad = 0;
    for (int w = 2; w <= 20; w += 3) begin
      btnc = 1'b1; quiet(w, k); bad += k;
      btnc = 1'b0; quiet(w, k); bad += k;
    end
    quiet(2 * DB, k);
    check("short_pulse_quiet", bad + k, 32'd0);
    check("short_pulse_frames", frames_rx, 32'd0);

    // Clean press of 0x3C, held through the frame; SW changes mid-frame.
    sw = 8'h3C;
    exp_q.push_back(8'h3C);
    btnc = 1'b1;
    repeat (DB + 4) @(negedge clk);
    sw = 8'h00;
    wait_frames(1, FRAME + 200);
    repeat (FRAME) @(negedge clk);
    check("busy_len_3c", last_busy_len, FRAME);
    check("hold_no_repeat", frames_rx, 32'd1);
    btnc = 1'b0;
    repeat (DB + 10) @(negedge clk);

    // Three random characters with bouncy presses and long gaps.
    for (int i = 0; i < 3; i++) begin
      c = 8'($urandom);
      sw = c;
      exp_q.push_back(c);
      press_bouncy(DB + 10);
      wait_frames(2 + i, FRAME + 400);
      repeat (10000) @(negedge clk);
    end

    // 0xFF: even-parity instance sends parity 0; a second press while busy is dropped.
    sw = 8'hFF;
    exp_q.push_back(8'hFF);
    btnc = 1'b1;
    repeat (DB + 8) @(negedge clk);
    btnc = 1'b0;
    repeat (DB + 5) @(negedge clk);
    check("busy_during_second_press", {31'd0, busy}, 32'd1);
    btnc = 1'b1;
    repeat (DB + 10) @(negedge clk);
    btnc = 1'b0;
    wait_frames(5, FRAME + 200);
    check("parity_even_ff", {31'd0, last_par_even}, 32'd0);
    repeat (2 * FRAME) @(negedge clk);
    check("one_frame_only", frames_rx, 32'd5);

    // Reset during DATA, with the button still held through reset.
    sw = 8'h96;
    exp_q.push_back(8'h96);
    btnc = 1'b1;
    k = 0;
    while (busy !== 1'b1 && k < 4 * DB) begin
      @(negedge clk);
      k++;
    end
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    repeat (3 * B) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_async_line", {31'd0, line}, 32'd1);
    check("reset_async_busy", {31'd0, busy}, 32'd0);
    sw = 8'hC3;
    exp_q.push_back(8'hC3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_frames(6, FRAME + 4 * DB);
    repeat (B) @(negedge clk);
    check("busy_len_after_reset", last_busy_len, FRAME);
    btnc = 1'b0;
    repeat (DB + 10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("total_frames", frames_rx, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
